iq_pack: RTL and testbench

IQ_PACK -- requirements
Module: iq_pack

---
 rtl/iq_pack_pkg.sv | 24 ++
 rtl/iq_pack_if.sv | 27 ++
 rtl/iq_pack_dequant.sv | 42 ++++
 rtl/iq_pack.sv | 89 ++++++++
 tb/tb_iq_pack.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/iq_pack_pkg.sv
// Shared types and constants for the IQ packer: sample widths, FSM state type
// and the dequantized I/Q pair layout.
package iq_pkg;

    localparam int IQ_BITS  = 10;
    localparam int SAMPLE_W = 16;
    localparam int QUANT_W  = 32;

    typedef enum logic {
        S_EVEN = 1'b0,
        S_ODD  = 1'b1
    } state_t;

    // i occupies the low half so two pairs concatenate straight into the output word
    typedef struct packed {
        logic [SAMPLE_W-1:0] q;
        logic [SAMPLE_W-1:0] i;
    } iq_pair_t;

    function automatic logic [4*SAMPLE_W-1:0] pack_word(input iq_pair_t p0, input iq_pair_t p1);
        return {p1, p0};
    endfunction

endpackage

// File: rtl/iq_pack_if.sv
// FIFO-side handshake bundle for iq_pack: two FWFT input FIFOs (I and Q) and
// one packed-word output FIFO. master = packer, slave = FIFO side.
interface iq_pack_if
    import iq_pkg::*;
#(
    parameter int OUT_WIDTH = 64
);
    logic                 in_rd_en;
    logic                 in_empty;
    logic [QUANT_W-1:0]   in_dout;
    logic                 in_rd_en_2;
    logic                 in_empty_2;
    logic [QUANT_W-1:0]   in_dout_2;
    logic                 out_wr_en;
    logic                 out_full;
    logic [OUT_WIDTH-1:0] out_din;

    modport master (
        output in_rd_en, in_rd_en_2, out_wr_en, out_din,
        input  in_empty, in_dout, in_empty_2, in_dout_2, out_full
    );

    modport slave (
        input  in_rd_en, in_rd_en_2, out_wr_en, out_din,
        output in_empty, in_dout, in_empty_2, in_dout_2, out_full
    );
endinterface

// File: rtl/iq_pack_dequant.sv
// Combinational dequantizer: signed divide by 2^BITS truncating toward zero,
// then narrow to 16 bits (saturate when IQ_PACK_SAT_EN is defined, else wrap).
module iq_dequant
    import iq_pkg::*;
#(
    parameter int BITS = IQ_BITS
) (
    input  logic [QUANT_W-1:0]  sample,
    output logic [SAMPLE_W-1:0] value
);
    logic signed [QUANT_W-1:0] shifted;
    logic signed [QUANT_W-1:0] quot;
    logic                      has_frac;

    // arithmetic shift floors; negative values with a fraction need +1 to truncate toward zero
    always_comb begin
        shifted  = $signed(sample) >>> BITS;
        has_frac = |sample[BITS-1:0];
        quot     = (sample[QUANT_W-1] && has_frac) ? shifted + 32'sd1 : shifted;
    end

`ifdef IQ_PACK_SAT_EN
    localparam logic signed [QUANT_W-1:0] SAT_MAX = 32'sd32767;
    localparam logic signed [QUANT_W-1:0] SAT_MIN = -32'sd32768;

    always_comb begin
        if (quot > SAT_MAX) begin
            value = 16'h7fff;
        end else if (quot < SAT_MIN) begin
            value = 16'h8000;
        end else begin
            value = quot[SAMPLE_W-1:0];
        end
    end
`else
    logic unused_hi;

    assign value     = quot[SAMPLE_W-1:0];
    assign unused_hi = ^quot[QUANT_W-1:SAMPLE_W];
`endif

endmodule

// File: rtl/iq_pack.sv
// Packs two consecutive dequantized I/Q pairs into one 64-bit output word.
// Narrowing mode selected by macro IQ_PACK_SAT_EN (inside iq_dequant).
//
// state  | meaning
// S_EVEN | waiting for pair 0; output FIFO state irrelevant
// S_ODD  | pair 0 held; waiting for pair 1 and output space
module iq_pack
    import iq_pkg::*;
#(
    parameter int BITS      = IQ_BITS,
    parameter int OUT_WIDTH = 64
) (
    input  logic      clock,
    input  logic      reset,
    iq_pack_if.master bus
);
    state_t              state;
    state_t              state_nxt;
    iq_pair_t            held;
    iq_pair_t            cur;
    logic [SAMPLE_W-1:0] deq_i;
    logic [SAMPLE_W-1:0] deq_q;
    logic                pair_avail;
    logic                pop;
    logic                push;

    iq_dequant #(.BITS(BITS)) u_deq_i (
        .sample (bus.in_dout),
        .value  (deq_i)
    );

    iq_dequant #(.BITS(BITS)) u_deq_q (
        .sample (bus.in_dout_2),
        .value  (deq_q)
    );

    assign cur        = {deq_q, deq_i};
    assign pair_avail = !bus.in_empty && !bus.in_empty_2;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_EVEN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_EVEN:  if (pair_avail)                  state_nxt = S_ODD;
            S_ODD:   if (pair_avail && !bus.out_full) state_nxt = S_EVEN;
            default: state_nxt = S_EVEN;
        endcase
    end

    // one pop strobe drives both FIFOs so I and Q can never drift apart
    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        if (!reset) begin
            case (state)
                S_EVEN: pop = pair_avail;
                S_ODD: begin
                    pop  = pair_avail && !bus.out_full;
                    push = pair_avail && !bus.out_full;
                end
                default: begin
                    pop  = 1'b0;
                    push = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            held <= '0;
        end else if (state == S_EVEN && pop) begin
            held <= cur;
        end
    end

    assign bus.in_rd_en   = pop;
    assign bus.in_rd_en_2 = pop;
    assign bus.out_wr_en  = push;
    assign bus.out_din    = OUT_WIDTH'(pack_word(held, cur));

endmodule

// File: tb/tb_iq_pack.sv
// Self-checking bench for iq_pack: FWFT FIFO models, a pair-level reference
// model producing expected packed words, and directed scenarios.
module tb_iq_pack;
    import iq_pkg::*;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    iq_pack_if #(.OUT_WIDTH(64)) bus ();

    iq_pack #(.BITS(10), .OUT_WIDTH(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    int          fi[$];
    int          fq[$];
    logic [63:0] exp_q[$];
    int          wr_cycles[$];
    bit          pend_v = 1'b0;
    logic [15:0] pend_i;
    logic [15:0] pend_q;
    int          vectors = 0;
    int          errors  = 0;
    int          cycle   = 0;
    int          pop_cnt = 0;
    int          wr_cnt  = 0;
    logic [63:0] last_word = '0;

    function automatic logic [15:0] dq(input int x);
        longint d;
        d = longint'(x) / 1024;
`ifdef IQ_PACK_SAT_EN
        if (d > 32767)  return 16'h7fff;
        if (d < -32768) return 16'h8000;
`endif
        return d[15:0];
    endfunction

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        bus.in_empty   = (fi.size() == 0);
        bus.in_dout    = (fi.size() != 0) ? fi[0] : 32'd0;
        bus.in_empty_2 = (fq.size() == 0);
        bus.in_dout_2  = (fq.size() != 0) ? fq[0] : 32'd0;
    endtask

    task automatic model_add(input int i, input int q);
        if (!pend_v) begin
            pend_i = dq(i);
            pend_q = dq(q);
            pend_v = 1'b1;
        end else begin
            exp_q.push_back({dq(q), dq(i), pend_q, pend_i});
            pend_v = 1'b0;
        end
    endtask

    task automatic push_pair(input int i, input int q);
        fi.push_back(i);
        fq.push_back(q);
        model_add(i, q);
        refresh();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((fi.size() != 0 || fq.size() != 0 || exp_q.size() != 0) && n < budget) begin
            tick(1);
            n++;
        end
        tick(1);
        check(n < budget, "drain_timeout", 64'(n), 64'(budget));
    endtask

    // compare process: strobe legality every cycle, written words against the model
    initial begin
        bit p;
        bit p2;
        forever begin
            @(negedge clock);
            cycle++;
            check(bus.in_rd_en == bus.in_rd_en_2, "rd_lockstep", 64'(bus.in_rd_en), 64'(bus.in_rd_en_2));
            if (bus.in_rd_en || bus.in_rd_en_2)
                check(!bus.in_empty && !bus.in_empty_2, "pop_when_empty", 64'({bus.in_empty, bus.in_empty_2}), 64'd0);
            if (bus.out_wr_en)
                check(!bus.out_full, "write_when_full", 64'(bus.out_full), 64'd0);
            if (reset)
                check(!(bus.in_rd_en || bus.in_rd_en_2 || bus.out_wr_en), "strobe_in_reset",
                      64'({bus.in_rd_en, bus.in_rd_en_2, bus.out_wr_en}), 64'd0);
            if (bus.out_wr_en) begin
                wr_cnt++;
                wr_cycles.push_back(cycle);
                last_word = bus.out_din;
                check(exp_q.size() != 0, "write_expected", bus.out_din, 64'd0);
                if (exp_q.size() != 0) begin
                    check(bus.out_din == exp_q[0], "out_din", bus.out_din, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
            p  = bus.in_rd_en;
            p2 = bus.in_rd_en_2;
            @(posedge clock);
            #1;
            if (p && fi.size() != 0)  void'(fi.pop_front());
            if (p2 && fq.size() != 0) void'(fq.pop_front());
            if (p) pop_cnt++;
            refresh();
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cycle);
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        int w0;
        logic [63:0] exp_sat;

        reset        = 1'b1;
        bus.out_full = 1'b0;
        refresh();
        tick(1);

        // pair waiting during reset must not be popped
        push_pair(1024, 2048);
        tick(4);
        check(pop_cnt == 0, "no_pop_in_reset", 64'(pop_cnt), 64'd0);
        reset = 1'b0;
        push_pair(-3072, 4096);
        wait_drain(50);
        check(last_word == 64'h0004_FFFD_0002_0001, "word_basic", last_word, 64'h0004_FFFD_0002_0001);
        check({dq(4096), dq(-3072), dq(2048), dq(1024)} == 64'h0004_FFFD_0002_0001, "model_pin_basic",
              {dq(4096), dq(-3072), dq(2048), dq(1024)}, 64'h0004_FFFD_0002_0001);

        // truncation toward zero
        push_pair(-1, -1024);
        push_pair(1023, 0);
        wait_drain(50);
        check(last_word == 64'h0000_0000_FFFF_0000, "word_trunc", last_word, 64'h0000_0000_FFFF_0000);
        check({dq(-1), dq(-1024)} == 32'h0000_FFFF, "model_pin_trunc", 64'({dq(-1), dq(-1024)}), 64'h0000_FFFF);

        // narrowing at the extremes
        push_pair(536870912, 0);
        push_pair(-536870912, 0);
        wait_drain(50);
`ifdef IQ_PACK_SAT_EN
        exp_sat = 64'h0000_8000_0000_7FFF;
`else
        exp_sat = 64'h0000_0000_0000_0000;
`endif
        check(last_word == exp_sat, "word_narrow", last_word, exp_sat);

        // throughput: 8 back-to-back pairs -> 4 words, one every two cycles
        w0 = wr_cycles.size();
        for (int k = 0; k < 8; k++) push_pair(k * 1024 + 5, -(k * 2048));
        wait_drain(60);
        check(wr_cycles.size() - w0 == 4, "burst_word_count", 64'(wr_cycles.size() - w0), 64'd4);
        if (wr_cycles.size() - w0 == 4)
            check(wr_cycles[w0 + 3] - wr_cycles[w0] == 6, "burst_spacing",
                  64'(wr_cycles[w0 + 3] - wr_cycles[w0]), 64'd6);

        // output full while holding pair 0 with pair 1 ready
        push_pair(7 * 1024, 3 * 1024);
        tick(2);
        bus.out_full = 1'b1;
        push_pair(100000, -100000);
        p0 = pop_cnt;
        w0 = wr_cnt;
        tick(20);
        check(pop_cnt == p0, "full_no_pop", 64'(pop_cnt), 64'(p0));
        check(wr_cnt == w0, "full_no_write", 64'(wr_cnt), 64'(w0));
        bus.out_full = 1'b0;
        tick(4);
        check(wr_cnt == w0 + 1, "full_release_one_write", 64'(wr_cnt), 64'(w0 + 1));
        check(fi.size() == 0, "full_release_drained", 64'(fi.size()), 64'd0);

        // I ready, Q empty while holding pair 0
        push_pair(-5000, 5000);
        tick(2);
        fi.push_back(2048);
        refresh();
        p0 = pop_cnt;
        tick(5);
        check(pop_cnt == p0, "q_empty_no_pop", 64'(pop_cnt), 64'(p0));
        fq.push_back(-2048);
        model_add(2048, -2048);
        refresh();
        tick(3);
        check(pop_cnt == p0 + 1, "q_arrive_pop", 64'(pop_cnt), 64'(p0 + 1));
        check(fi.size() == 0 && fq.size() == 0, "q_arrive_drained", 64'(fi.size() + fq.size()), 64'd0);
        wait_drain(20);

        // reset discards the held pair
        p0 = pop_cnt;
        push_pair(5000, 6000);
        tick(2);
        check(pop_cnt == p0 + 1, "pre_reset_capture", 64'(pop_cnt), 64'(p0 + 1));
        reset  = 1'b1;
        pend_v = 1'b0;
        tick(2);
        reset = 1'b0;
        w0 = wr_cnt;
        push_pair(11264, -11264);
        push_pair(-20480, 30720);
        wait_drain(50);
        check(wr_cnt == w0 + 1, "post_reset_one_write", 64'(wr_cnt), 64'(w0 + 1));
        check(last_word == 64'h001E_FFEC_FFF5_000B, "post_reset_word", last_word, 64'h001E_FFEC_FFF5_000B);

        // trailing odd pair is held, never emitted
        w0 = wr_cnt;
        p0 = pop_cnt;
        push_pair(1, 1);
        tick(10);
        check(pop_cnt == p0 + 1, "trailing_popped", 64'(pop_cnt), 64'(p0 + 1));
        check(wr_cnt == w0, "trailing_no_write", 64'(wr_cnt), 64'(w0));

        check(exp_q.size() == 0, "expected_words_left", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
